cpu_multicycle_core: RTL and testbench

- Parametrised successor to the 4-bit single-cycle CPU.
- Multi-cycle core with a data width set by DATA_W and a PC width set by PC_W.
- Fetches 16-bit instructions over a req/ack handshake from an external instruction memory.
- Holds an internal 4-entry register file and an internal data memory; sequences each instruction through a FETCH/DECODE/EXECUTE/MEM/WB state machine with branch and halt support.

---
 rtl/cpu_multicycle_core.sv | 169 ++++++++++++++++
 tb/tb_cpu_multicycle_core.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle_core.sv
// rtl/cpu_multicycle_core.sv - parametrised multi-cycle CPU core with req/ack instruction fetch
// Internal 4-entry register file and data memory; FETCH/DECODE/EXEC/MEM/WB sequencing.
module cpu_multicycle_core #(
  parameter int DATA_W     = 4,
  parameter int PC_W       = 4,
  parameter int DMEM_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic [15:0]       instr,
  output logic              reg_we,
  output logic [1:0]        reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] alu_result,
  output logic              carry,
  output logic              zero,
  output logic              halted
);

  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_CBZ  = 4'h8;
  localparam logic [3:0] OP_B    = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            curState;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] opX, opY, opZ, memData;
  logic [3:0]        op;
  logic [DATA_W-1:0] immData;
  logic [PC_W-1:0]   immPc;
  logic [DATA_W:0]   aluWide;
  logic [DATA_W-1:0] aluRes;
  logic              aluCarry;
  logic [AW-1:0]     memAddr;
  logic [PC_W-1:0]   pcNext;

  assign op        = instr[15:12];
  assign immData   = DATA_W'($signed(instr[5:0]));
  assign immPc     = PC_W'($signed(instr[5:0]));
  assign memAddr   = alu_result[AW-1:0];
  assign pcNext    = pc + PC_W'(1);

  assign state     = curState;
  assign imem_req  = (curState == S_FETCH);
  assign imem_addr = pc;
  assign reg_we    = (curState == S_WB);
  assign reg_waddr = instr[11:10];
  assign reg_wdata = (op == OP_LDR) ? memData : alu_result;

  // One extra bit holds carry-out; for SUB it holds the borrow, inverted below.
  always_comb begin
    aluWide = '0;
    case (op)
      OP_ADD:  aluWide = {1'b0, opX} + {1'b0, opY};
      OP_SUB:  aluWide = {1'b0, opX} - {1'b0, opY};
      OP_AND:  aluWide = {1'b0, opX & opY};
      OP_OR:   aluWide = {1'b0, opX | opY};
      default: aluWide = {1'b0, opX} + {1'b0, immData};
    endcase
  end

  assign aluRes   = aluWide[DATA_W-1:0];
  assign aluCarry = (op == OP_SUB) ? ~aluWide[DATA_W] : aluWide[DATA_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      curState   <= S_FETCH;
      pc         <= '0;
      instr      <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      alu_result <= '0;
      halted     <= 1'b0;
      opX        <= '0;
      opY        <= '0;
      opZ        <= '0;
      memData    <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else begin
      case (curState)
        S_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            curState <= S_DECODE;
          end
        end
        S_DECODE: begin
          opX      <= regs[instr[9:8]];
          opY      <= regs[instr[7:6]];
          opZ      <= regs[instr[11:10]];
          curState <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
              alu_result <= aluRes;
              carry      <= aluCarry;
              zero       <= (aluRes == '0);
              curState   <= S_WB;
            end
            OP_LDR, OP_STR: begin
              alu_result <= aluRes;
              curState   <= S_MEM;
            end
            OP_CBZ: begin
              pc       <= (opZ == '0) ? pc + immPc : pcNext;
              curState <= S_FETCH;
            end
            OP_B: begin
              pc       <= pc + immPc;
              curState <= S_FETCH;
            end
            OP_HALT: begin
              halted   <= 1'b1;
              curState <= S_HALT;
            end
            default: begin
              pc       <= pcNext;
              curState <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (op == OP_STR) begin
            dmem[memAddr] <= opZ;
            pc            <= pcNext;
            curState      <= S_FETCH;
          end else begin
            memData  <= dmem[memAddr];
            curState <= S_WB;
          end
        end
        S_WB: begin
          regs[instr[11:10]] <= reg_wdata;
          pc                 <= pcNext;
          curState           <= S_FETCH;
        end
        S_HALT: curState <= S_HALT;
        default: curState <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle_core.sv
// tb/tb_cpu_multicycle_core.sv - self-checking bench for cpu_multicycle_core
// Directed programs plus random straight-line/forward-branch programs against an ISA-level model.
module tb_cpu_multicycle_core;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog [16];
  int expW[$];
  int got4[$];
  int got8[$];
  int expPc, expC, expZ, expCycles;

  logic        reset4 = 1'b0, ackOn4 = 1'b1;
  logic        imemReq4, imemAck4, regWe4, carry4, zero4, halted4;
  logic [3:0]  imemAddr4, pc4, regWdata4, aluResult4;
  logic [15:0] imemRdata4, instr4;
  logic [2:0]  state4;
  logic [1:0]  regWaddr4;

  logic        reset8 = 1'b0, ackOn8 = 1'b1;
  logic        imemReq8, imemAck8, regWe8, carry8, zero8, halted8;
  logic [3:0]  imemAddr8, pc8;
  logic [7:0]  regWdata8, aluResult8;
  logic [15:0] imemRdata8, instr8;
  logic [2:0]  state8;
  logic [1:0]  regWaddr8;

  assign imemAck4   = imemReq4 & ackOn4;
  assign imemRdata4 = prog[imemAddr4];
  assign imemAck8   = imemReq8 & ackOn8;
  assign imemRdata8 = prog[imemAddr8];

  cpu_multicycle_core #(.DATA_W(4), .PC_W(4), .DMEM_DEPTH(16)) dut4 (
    .clock(clock), .reset(reset4), .imem_req(imemReq4), .imem_addr(imemAddr4),
    .imem_ack(imemAck4), .imem_rdata(imemRdata4), .pc(pc4), .state(state4),
    .instr(instr4), .reg_we(regWe4), .reg_waddr(regWaddr4), .reg_wdata(regWdata4),
    .alu_result(aluResult4), .carry(carry4), .zero(zero4), .halted(halted4));

  cpu_multicycle_core #(.DATA_W(8), .PC_W(4), .DMEM_DEPTH(16)) dut8 (
    .clock(clock), .reset(reset8), .imem_req(imemReq8), .imem_addr(imemAddr8),
    .imem_ack(imemAck8), .imem_rdata(imemRdata8), .pc(pc8), .state(state8),
    .instr(instr8), .reg_we(regWe8), .reg_waddr(regWaddr8), .reg_wdata(regWdata8),
    .alu_result(aluResult8), .carry(carry8), .zero(zero8), .halted(halted8));

  always @(negedge clock) begin
    if (reset4 && regWe4) got4.push_back((int'(regWaddr4) << 16) | int'(regWdata4));
    if (reset8 && regWe8) got8.push_back((int'(regWaddr8) << 16) | int'(regWdata8));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rz, input int rx, input int ry, input int imm);
    logic [31:0] o, a, b, c, d;
    o = op; a = rz; b = rx; c = ry; d = imm;
    return {o[3:0], a[1:0], b[1:0], c[1:0], d[5:0]};
  endfunction

  task automatic clearProg();
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
  endtask

  // Instruction-level interpreter: executes prog with plain integer arithmetic.
  task automatic modelRun(input int dw);
    int r[4];
    int dm[16];
    int pc, mask, w, op, rz, rx, ry, imm, s, a, res;
    mask = (1 << dw) - 1;
    expW.delete();
    pc = 0; expC = 0; expZ = 0; expCycles = 0;
    for (int i = 0; i < 4; i++) r[i] = 0;
    for (int i = 0; i < 16; i++) dm[i] = 0;
    for (int step = 0; step < 200; step++) begin
      w = int'(prog[pc]);
      op = (w >> 12) & 15; rz = (w >> 10) & 3; rx = (w >> 8) & 3; ry = (w >> 6) & 3;
      imm = w & 63;
      if (imm >= 32) imm -= 64;
      if (op == 15) begin
        expCycles += 3;
        break;
      end
      if (op >= 1 && op <= 5) begin
        case (op)
          1: s = r[rx] + r[ry];
          2: s = r[rx] - r[ry];
          3: s = r[rx] & r[ry];
          4: s = r[rx] | r[ry];
          default: s = r[rx] + (imm & mask);
        endcase
        res = s & mask;
        expC = (op == 2) ? int'(r[rx] >= r[ry]) : int'(s > mask);
        expZ = int'(res == 0);
        r[rz] = res;
        expW.push_back((rz << 16) | res);
        pc = (pc + 1) & 15;
        expCycles += 4;
      end else if (op == 6 || op == 7) begin
        a = ((r[rx] + imm) & mask) & 15;
        if (op == 6) begin
          r[rz] = dm[a];
          expW.push_back((rz << 16) | r[rz]);
          expCycles += 5;
        end else begin
          dm[a] = r[rz];
          expCycles += 4;
        end
        pc = (pc + 1) & 15;
      end else if (op == 8 || op == 9) begin
        pc = (op == 9 || r[rz] == 0) ? ((pc + imm) & 15) : ((pc + 1) & 15);
        expCycles += 3;
      end else begin
        pc = (pc + 1) & 15;
        expCycles += 3;
      end
    end
    expPc = pc;
  endtask

  task automatic runProg4(input int stall0, input bit randAck, output int cycles);
    reset4 = 1'b0;
    ackOn4 = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    chk("rst_state", state4, 0);
    chk("rst_pc", pc4, 0);
    chk("rst_instr_ack_ignored", instr4, 0);
    chk("rst_halted", halted4, 0);
    chk("rst_flags", {carry4, zero4}, 0);
    chk("rst_alu", aluResult4, 0);
    got4.delete();
    @(negedge clock);
    reset4 = 1'b1;
    cycles = 0;
    if (stall0 > 0) begin
      ackOn4 = 1'b0;
      for (int i = 0; i < stall0; i++) begin
        @(posedge clock);
        cycles++;
        #1;
        chk("stall_fetch", {state4, imemReq4, imemAddr4, pc4}, {3'd0, 1'b1, 4'd0, 4'd0});
        chk("stall_instr", instr4, 0);
      end
      ackOn4 = 1'b1;
    end
    while (!halted4 && cycles < 3000) begin
      @(posedge clock);
      cycles++;
      #1;
      if (randAck) ackOn4 = ($urandom_range(0, 3) != 0);
    end
    ackOn4 = 1'b1;
    chk("halted", halted4, 1);
  endtask

  task automatic checkRun4(input string tag, input int cycles, input int stall, input bit cycleCheck);
    chk({tag, "_nwrites"}, got4.size(), expW.size());
    for (int i = 0; i < got4.size() && i < expW.size(); i++) chk({tag, "_write"}, got4[i], expW[i]);
    chk({tag, "_pc"}, pc4, expPc);
    chk({tag, "_carry"}, carry4, expC);
    chk({tag, "_zero"}, zero4, expZ);
    chk({tag, "_state"}, state4, 5);
    chk({tag, "_req_off"}, imemReq4, 0);
    if (cycleCheck) chk({tag, "_cycles"}, cycles, expCycles + stall);
  endtask

  initial begin
    int cyc, n;
    repeat (2) @(negedge clock);

    clearProg();
    prog[0] = enc(5, 1, 0, 0, 5);
    prog[1] = enc(5, 2, 0, 0, 3);
    prog[2] = enc(1, 3, 1, 2, 0);
    prog[3] = enc(15, 0, 0, 0, 0);
    modelRun(4);
    runProg4(0, 1'b0, cyc);
    checkRun4("basic", cyc, 0, 1'b1);
    chk("basic_cycles_const", cyc, 15);
    chk("basic_r3", (got4.size() > 2) ? got4[2] : -1, (3 << 16) | 8);
    chk("basic_pc_const", pc4, 3);

    runProg4(5, 1'b0, cyc);
    checkRun4("stall", cyc, 5, 1'b1);

    clearProg();
    prog[0] = enc(5, 1, 0, 0, 7);
    prog[1] = enc(5, 1, 1, 0, -7);
    prog[2] = enc(15, 0, 0, 0, 0);
    modelRun(4);
    runProg4(0, 1'b0, cyc);
    checkRun4("addi_neg", cyc, 0, 1'b1);
    chk("addi_neg_flags_const", {carry4, zero4}, 2'b11);
    prog[2] = enc(2, 2, 0, 1, 0);
    prog[3] = enc(15, 0, 0, 0, 0);
    modelRun(4);
    runProg4(0, 1'b0, cyc);
    checkRun4("sub_zero", cyc, 0, 1'b1);
    chk("sub_zero_carry_const", carry4, 1);

    clearProg();
    prog[0] = enc(5, 1, 0, 0, 9);
    prog[1] = enc(7, 1, 0, 0, 2);
    prog[2] = enc(6, 3, 0, 0, 2);
    prog[3] = enc(15, 0, 0, 0, 0);
    modelRun(4);
    runProg4(0, 1'b0, cyc);
    checkRun4("strldr", cyc, 0, 1'b1);
    chk("strldr_cycles_const", cyc, 4 + 4 + 5 + 3);
    chk("strldr_r3", (got4.size() > 1) ? got4[1] : -1, (3 << 16) | 9);

    clearProg();
    prog[0] = enc(5, 1, 0, 0, 3);
    prog[1] = enc(5, 1, 1, 0, -1);
    prog[2] = enc(8, 1, 0, 0, 2);
    prog[3] = enc(9, 0, 0, 0, -2);
    prog[4] = enc(15, 0, 0, 0, 0);
    modelRun(4);
    runProg4(0, 1'b0, cyc);
    checkRun4("loop", cyc, 0, 1'b1);
    chk("loop_pc_const", pc4, 4);
    chk("loop_nwrites_const", got4.size(), 4);

    clearProg();
    prog[0]  = enc(8, 1, 0, 0, 3);
    prog[1]  = enc(15, 0, 0, 0, 0);
    prog[3]  = enc(5, 1, 0, 0, 1);
    prog[4]  = enc(9, 0, 0, 0, 11);
    prog[15] = enc(9, 0, 0, 0, 1);
    modelRun(4);
    runProg4(0, 1'b0, cyc);
    checkRun4("pcwrap", cyc, 0, 1'b1);
    chk("pcwrap_pc_const", pc4, 1);

    clearProg();
    prog[0] = enc(5, 1, 0, 0, 5);
    prog[1] = enc(5, 2, 0, 0, 3);
    prog[2] = enc(1, 3, 1, 2, 0);
    prog[3] = enc(15, 0, 0, 0, 0);
    reset4 = 1'b0;
    @(negedge clock);
    got4.delete();
    reset4 = 1'b1;
    n = 0;
    while (!(state4 == 3'd4 && instr4[15:12] == 4'd1) && n < 200) begin
      @(posedge clock);
      n++;
      #1;
    end
    chk("wbrst_reached", state4, 4);
    reset4 = 1'b0;
    #1;
    chk("wbrst_pc", pc4, 0);
    chk("wbrst_state", state4, 0);
    chk("wbrst_we", regWe4, 0);
    @(posedge clock);
    #1;
    chk("wbrst_late_ack", instr4, 0);
    chk("wbrst_nwrites", got4.size(), 2);

    clearProg();
    prog[0] = enc(5, 1, 0, 0, 31);
    prog[1] = enc(5, 2, 0, 0, 31);
    prog[2] = enc(1, 3, 1, 2, 0);
    prog[3] = enc(15, 0, 0, 0, 0);
    modelRun(8);
    got8.delete();
    @(negedge clock);
    reset8 = 1'b1;
    cyc = 0;
    while (!halted8 && cyc < 500) begin
      @(posedge clock);
      cyc++;
      #1;
    end
    chk("w8_halted", halted8, 1);
    chk("w8_cycles", cyc, expCycles);
    chk("w8_nwrites", got8.size(), expW.size());
    for (int i = 0; i < got8.size() && i < expW.size(); i++) chk("w8_write", got8[i], expW[i]);
    chk("w8_r3_const", (got8.size() > 2) ? got8[2] : -1, (3 << 16) | 62);
    chk("w8_carry", carry8, 0);
    chk("w8_pc", pc8, 3);
    reset8 = 1'b0;

    for (int t = 0; t < 10; t++) begin
      clearProg();
      for (int p = 0; p < 15; p++) begin
        int op, imm;
        op = int'($urandom_range(0, 9));
        imm = (op == 8 || op == 9) ? int'($urandom_range(1, 15 - p)) : int'($urandom_range(0, 63));
        prog[p] = enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), imm);
      end
      prog[15] = enc(15, 0, 0, 0, 0);
      modelRun(4);
      runProg4(0, (t % 2) == 1, cyc);
      checkRun4("rand", cyc, 0, (t % 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
